// File: rtl/rom_2port_arbiter.sv
// ============================================================================
// Module      : rom_2port_arbiter
// Description : Round-robin sharing of a two-port registered-read ROM among
//               NUM_REQ requesters, with in-order tagged response routing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_2port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int AWIDTH  = 8,
    parameter int DWIDTH  = 8,
    parameter int ROM_LAT = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*AWIDTH-1:0]   req_addr,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [NUM_REQ*DWIDTH-1:0]   rsp_data,
    output logic [AWIDTH-1:0]           rom_address_a,
    output logic [AWIDTH-1:0]           rom_address_b,
    input  logic [DWIDTH-1:0]           rom_qa,
    input  logic [DWIDTH-1:0]           rom_qb
);

    localparam int              PW     = $clog2(NUM_REQ);
    localparam logic [PW:0]     C_NUM  = (PW+1)'(NUM_REQ);
    localparam logic [PW-1:0]   C_LAST = PW'(NUM_REQ - 1);

    logic [PW-1:0]                  ptr_q, ptr_d;
    logic                           gnt_a, gnt_b;
    logic [PW-1:0]                  id_a, id_b;
    logic [PW:0]                    scan_idx;
    logic [AWIDTH-1:0]              addr_lane [NUM_REQ];
    logic [AWIDTH-1:0]              addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [ROM_LAT-1:0]             tv_a_q, tv_a_d, tv_b_q, tv_b_d;
    logic [ROM_LAT-1:0][PW-1:0]     tid_a_q, tid_a_d, tid_b_q, tid_b_d;
    logic [NUM_REQ-1:0]             rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ*DWIDTH-1:0]      rsp_data_q, rsp_data_d;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] id);
        return (id == C_LAST) ? '0 : id + PW'(1);
    endfunction

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
            assign addr_lane[i] = req_addr[i*AWIDTH +: AWIDTH];
        end
    endgenerate

    // Rotational scan from ptr: first valid takes port A, the next takes B.
    always_comb begin
        gnt_a    = 1'b0;
        gnt_b    = 1'b0;
        id_a     = '0;
        id_b     = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, ptr_q} + (PW+1)'(k);
            if (scan_idx >= C_NUM) begin
                scan_idx = scan_idx - C_NUM;
            end
            if (!rst && req_valid[scan_idx[PW-1:0]]) begin
                if (!gnt_a) begin
                    gnt_a = 1'b1;
                    id_a  = scan_idx[PW-1:0];
                end else if (!gnt_b) begin
                    gnt_b = 1'b1;
                    id_b  = scan_idx[PW-1:0];
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (gnt_a) req_ready[id_a] = 1'b1;
        if (gnt_b) req_ready[id_b] = 1'b1;

        addr_a_d = gnt_a ? addr_lane[id_a] : addr_a_q;
        addr_b_d = gnt_b ? addr_lane[id_b] : addr_b_q;

        ptr_d = ptr_q;
        if (gnt_b) begin
            ptr_d = wrap_inc(id_b);
        end else if (gnt_a) begin
            ptr_d = wrap_inc(id_a);
        end

        tv_a_d     = '0;
        tv_b_d     = '0;
        tid_a_d    = '0;
        tid_b_d    = '0;
        tv_a_d[0]  = gnt_a;
        tv_b_d[0]  = gnt_b;
        tid_a_d[0] = id_a;
        tid_b_d[0] = id_b;
        for (int s = 1; s < ROM_LAT; s++) begin
            tv_a_d[s]  = tv_a_q[s-1];
            tv_b_d[s]  = tv_b_q[s-1];
            tid_a_d[s] = tid_a_q[s-1];
            tid_b_d[s] = tid_b_q[s-1];
        end
    end

    // Tag pipe output lines up with ROM data; the two ids never collide.
    always_comb begin
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (tv_a_q[ROM_LAT-1] && (tid_a_q[ROM_LAT-1] == PW'(i))) begin
                rsp_valid_d[i]                  = 1'b1;
                rsp_data_d[i*DWIDTH +: DWIDTH]  = rom_qa;
            end
            if (tv_b_q[ROM_LAT-1] && (tid_b_q[ROM_LAT-1] == PW'(i))) begin
                rsp_valid_d[i]                  = 1'b1;
                rsp_data_d[i*DWIDTH +: DWIDTH]  = rom_qb;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            tv_a_q      <= '0;
            tv_b_q      <= '0;
            tid_a_q     <= '0;
            tid_b_q     <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            tv_a_q      <= tv_a_d;
            tv_b_q      <= tv_b_d;
            tid_a_q     <= tid_a_d;
            tid_b_q     <= tid_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rom_address_a = addr_a_d;
    assign rom_address_b = addr_b_d;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;

endmodule

`default_nettype wire

// File: tb/tb_rom_2port_arbiter.sv
// ============================================================================
// Module      : tb_rom_2port_arbiter
// Description : Bench for rom_2port_arbiter with ROM model and scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rom_2port_arbiter;

    localparam int N       = 4;
    localparam int AW      = 8;
    localparam int DW      = 8;
    localparam int LAT     = 1;
    localparam int LAT3    = 3;
    localparam int MAXWAIT = (N + 1) / 2 - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_addr  = '0;
    logic [N-1:0]    req_ready, rsp_valid;
    logic [N*DW-1:0] rsp_data;
    logic [AW-1:0]   rom_address_a, rom_address_b;
    logic [DW-1:0]   rom_qa, rom_qb;

    logic [N-1:0]    v3 = '0;
    logic [N*AW-1:0] a3 = '0;
    logic [N-1:0]    rdy3, rv3;
    logic [N*DW-1:0] rd3;
    logic [AW-1:0]   aa3, ab3;
    logic [DW-1:0]   qa3, qb3;

    rom_2port_arbiter #(.NUM_REQ(N), .AWIDTH(AW), .DWIDTH(DW), .ROM_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rom_address_a(rom_address_a), .rom_address_b(rom_address_b),
        .rom_qa(rom_qa), .rom_qb(rom_qb)
    );

    rom_2port_arbiter #(.NUM_REQ(N), .AWIDTH(AW), .DWIDTH(DW), .ROM_LAT(LAT3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(v3), .req_addr(a3),
        .req_ready(rdy3), .rsp_valid(rv3), .rsp_data(rd3),
        .rom_address_a(aa3), .rom_address_b(ab3),
        .rom_qa(qa3), .rom_qb(qb3)
    );

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        return a ^ 8'hA5;
    endfunction

    // ROM models: addresses sampled mid-cycle, then read through a LAT-deep register pipe.
    logic [AW-1:0] sa, sb, sa3, sb3;
    logic [DW-1:0] pa [LAT];
    logic [DW-1:0] pb [LAT];
    logic [DW-1:0] pa3 [LAT3];
    logic [DW-1:0] pb3 [LAT3];
    always @(negedge clk) begin
        sa = rom_address_a; sb = rom_address_b; sa3 = aa3; sb3 = ab3;
    end
    always @(posedge clk) begin
        pa[0]  <= mem_rd(sa);
        pb[0]  <= mem_rd(sb);
        pa3[0] <= mem_rd(sa3);
        pb3[0] <= mem_rd(sb3);
        for (int j = 1; j < LAT; j++) begin
            pa[j] <= pa[j-1];
            pb[j] <= pb[j-1];
        end
        for (int j = 1; j < LAT3; j++) begin
            pa3[j] <= pa3[j-1];
            pb3[j] <= pb3[j-1];
        end
    end
    assign rom_qa = pa[LAT-1];
    assign rom_qb = pb[LAT-1];
    assign qa3    = pa3[LAT3-1];
    assign qb3    = pb3[LAT3-1];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: grants, held addresses, per-lane expected responses.
    typedef struct {
        int            due;
        logic [DW-1:0] d;
    } exp_t;

    exp_t          q [N][$];
    int            m_ptr = 0;
    logic [AW-1:0] m_ha  = '0;
    logic [AW-1:0] m_hb  = '0;
    logic [DW-1:0] m_data [N];
    int            waitc [N];
    int            cyc   = 0;
    bit            armed = 1'b0;
    logic [N-1:0]  hs_last = '0;

    function automatic logic [AW-1:0] lane_addr(input int id);
        return req_addr[id*AW +: AW];
    endfunction

    always @(negedge clk) begin
        int            wa, wb, id;
        logic [N-1:0]  exp_rdy, exp_rv;
        logic [AW-1:0] ea, eb;
        cyc++;
        exp_rv = '0;
        for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0 && q[i][0].due == cyc) begin
                exp_rv[i] = 1'b1;
                m_data[i] = q[i][0].d;
                void'(q[i].pop_front());
            end
        end
        wa = -1;
        wb = -1;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                id = (m_ptr + k) % N;
                if (req_valid[id]) begin
                    if (wa < 0) wa = id;
                    else if (wb < 0) wb = id;
                end
            end
        end
        exp_rdy = '0;
        ea = m_ha;
        eb = m_hb;
        if (wa >= 0) begin exp_rdy[wa] = 1'b1; ea = lane_addr(wa); end
        if (wb >= 0) begin exp_rdy[wb] = 1'b1; eb = lane_addr(wb); end
        if (armed) begin
            chk("rsp_valid", rsp_valid, exp_rv);
            for (int i = 0; i < N; i++) chk("rsp_data", rsp_data[i*DW +: DW], m_data[i]);
            chk("req_ready", req_ready, exp_rdy);
            chk("rom_address_a", rom_address_a, ea);
            chk("rom_address_b", rom_address_b, eb);
            for (int i = 0; i < N; i++) begin
                if (rst || !req_valid[i] || req_ready[i]) begin
                    waitc[i] = 0;
                end else begin
                    waitc[i]++;
                    chk("wait_bound", waitc[i] <= MAXWAIT, 1'b1);
                end
            end
        end
        if (wa >= 0) q[wa].push_back('{cyc + LAT + 1, mem_rd(ea)});
        if (wb >= 0) q[wb].push_back('{cyc + LAT + 1, mem_rd(eb)});
        if (wb >= 0) m_ptr = (wb + 1) % N;
        else if (wa >= 0) m_ptr = (wa + 1) % N;
        m_ha = ea;
        m_hb = eb;
        hs_last = req_ready;
        if (rst) begin
            m_ptr = 0;
            m_ha  = '0;
            m_hb  = '0;
            for (int i = 0; i < N; i++) begin
                q[i].delete();
                m_data[i] = '0;
                waitc[i]  = 0;
            end
            armed = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;

        // Single request, lane 2, address 0x10.
        req_valid = 4'b0100;
        req_addr  = 32'h0010_0000;
        sample();
        chk("t1_ready", req_ready, 4'b0100);
        chk("t1_addr_a", rom_address_a, 8'h10);
        chk("t1_addr_b", rom_address_b, 8'h00);
        tick();
        req_valid = '0;
        sample();
        chk("t1_no_early_rsp", rsp_valid, 4'b0000);
        tick();
        sample();
        chk("t1_rsp_valid", rsp_valid, 4'b0100);
        chk("t1_rsp_data", rsp_data[2*DW +: DW], 8'hB5);
        chk("t1_addr_b_held", rom_address_b, 8'h00);

        // All four valid from ptr 0, then requesters 1 and 3 from ptr 2.
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = 4'b1111;
        req_addr  = 32'h3322_1100;
        sample(); chk("t2_c0", req_ready, 4'b0011); tick();
        sample(); chk("t2_c1", req_ready, 4'b1100); tick();
        sample(); chk("t2_c2", req_ready, 4'b0011); tick();
        req_valid = 4'b1010;
        sample();
        chk("t3_ready0", req_ready, 4'b1010);
        chk("t3_addr_a", rom_address_a, 8'h33);
        chk("t3_addr_b", rom_address_b, 8'h11);
        tick();
        sample();
        chk("t3_ready1", req_ready, 4'b1010);
        tick();
        req_valid = '0;
        sample();
        chk("t3_rsp_valid", rsp_valid, 4'b1010);
        chk("t3_rsp_lane3", rsp_data[3*DW +: DW], 8'h96);
        chk("t3_rsp_lane1", rsp_data[1*DW +: DW], 8'hB4);
        tick();

        // Two grants, then a one-cycle reset: nothing may come back.
        req_valid = 4'b0011;
        tick();
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sample();
            chk("t5_rsp_valid", rsp_valid, 4'b0000);
            chk("t5_rsp_data", rsp_data, 32'h0);
            chk("t5_addr_a", rom_address_a, 8'h00);
            chk("t5_addr_b", rom_address_b, 8'h00);
            tick();
        end

        // ROM_LAT=3 instance: back-to-back lane 0 reads of 1,2,3.
        for (int k = 0; k < 8; k++) begin
            if (k < 3) begin
                v3 = 4'b0001;
                a3 = 32'(k + 1);
            end else begin
                v3 = '0;
                a3 = '0;
            end
            sample();
            if (k < 3) chk("t4_ready", rdy3, 4'b0001);
            chk("t4_rsp_valid", rv3, (k >= 4 && k <= 6) ? 4'b0001 : 4'b0000);
            if (k >= 4 && k <= 6) chk("t4_rsp_data", rd3[DW-1:0], 8'(k - 3) ^ 8'hA5);
            tick();
        end

        // Randomized persistent requesters with occasional mid-flight reset.
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || hs_last[i]) req_valid[i] = ($urandom_range(0, 99) < 60);
                req_addr[i*AW +: AW] = 8'($urandom_range(0, 255));
            end
            rst = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst = 1'b0;
        req_valid = '0;
        repeat (LAT + 4) tick();
        for (int i = 0; i < N; i++) chk("drain", 64'(q[i].size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
